// File: rtl/spi_arb_master.sv
`default_nettype none
// spi_arb_master: round-robin arbiter for two requesters sharing one SPI mode-0 port.
// Each grant runs one full-duplex DATA_W-bit transfer and returns the received word to the winner.
module spi_arb_master #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_ss_n,
  output logic              busy,
  output logic              grant
);
  localparam int PH_W  = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, GAP} state_t;

  state_t              r_state, w_state_nxt;
  logic [PH_W-1:0]     r_phase;
  logic [BIT_W-1:0]    r_bit;
  logic [DATA_W-1:0]   r_tx, r_rx;
  logic                r_grant, r_last_grant, r_armed;
  logic                w_phase_end, w_win, w_pick1, w_in_xfer;

  assign w_phase_end = (r_phase == PH_LAST);
  // r_armed keeps ready low while reset is held and on the first cycle after release.
  assign w_win       = r_armed & (r_state == IDLE) & (req0_valid | req1_valid);
  assign w_pick1     = req1_valid & (~req0_valid | ~r_last_grant);
  assign req0_ready  = w_win & ~w_pick1;
  assign req1_ready  = w_win & w_pick1;
  assign grant       = r_grant;
  assign w_in_xfer   = (r_state == LEAD) | (r_state == HIGH) | (r_state == LOW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    spi_ss_n    = 1'b1;
    spi_sclk    = 1'b0;
    spi_mosi    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE:    if (w_win) w_state_nxt = LEAD;
      LEAD:    if (w_phase_end) w_state_nxt = HIGH;
      HIGH:    if (w_phase_end) w_state_nxt = LOW;
      LOW:     if (w_phase_end) w_state_nxt = (r_bit == '0) ? GAP : HIGH;
      GAP:     if (w_phase_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (r_state != IDLE) busy = 1'b1;
    if (w_in_xfer) begin
      spi_ss_n = 1'b0;
      spi_mosi = r_tx[DATA_W-1];
    end
    if (r_state == HIGH) spi_sclk = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_armed      <= 1'b0;
      r_phase      <= '0;
      r_bit        <= '0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_data    <= '0;
      rsp1_data    <= '0;
    end else begin
      r_armed    <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (w_state_nxt != r_state) r_phase <= '0;
      else if (r_state != IDLE)   r_phase <= r_phase + PH_W'(1);
      case (r_state)
        IDLE: if (w_win) begin
          r_tx         <= w_pick1 ? req1_data : req0_data;
          r_grant      <= w_pick1;
          r_last_grant <= w_pick1;
          r_bit        <= BIT_TOP;
        end
        LEAD: if (w_phase_end) r_rx <= {r_rx[DATA_W-2:0], spi_miso};
        HIGH: if (w_phase_end && r_bit != '0) r_tx <= {r_tx[DATA_W-2:0], 1'b0};
        LOW: if (w_phase_end) begin
          if (r_bit == '0) begin
            // Final LOW was the SS hold time; hand the word back as GAP begins.
            if (r_grant) begin
              rsp1_valid <= 1'b1;
              rsp1_data  <= r_rx;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_data  <= r_rx;
            end
          end else begin
            r_bit <= r_bit - BIT_W'(1);
            r_rx  <= {r_rx[DATA_W-2:0], spi_miso};
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_spi_arb_master.sv
`default_nettype none
// tb_spi_arb_master: directed, table-driven checks of spi_arb_master (default and minimum-divider builds).
module tb_spi_arb_master;
  localparam int DW      = 16;
  localparam int CD      = 4;
  localparam int SS_LOW  = CD * (2 * DW + 1);
  localparam int SPACING = 1 + SS_LOW + CD;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic spi_sclk, spi_mosi, spi_miso, spi_ss_n, busy, grant;

  logic m_req0_valid = 1'b0, m_req1_valid = 1'b0;
  logic [7:0] m_req0_data = '0, m_req1_data = '0;
  logic m_req0_ready, m_req1_ready, m_rsp0_valid, m_rsp1_valid;
  logic [7:0] m_rsp0_data, m_rsp1_data;
  logic m_sclk, m_mosi, m_miso, m_ss_n, m_busy, m_grant;

  logic loop_mode = 1'b1;
  logic [DW-1:0] slv_word = '0;
  logic [3:0] slv_idx = 4'd15;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int prev_acc = 0;
  string tag = "reset";

  spi_arb_master #(.DATA_W(DW), .CLK_DIV(CD)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ss_n(spi_ss_n),
    .busy(busy), .grant(grant)
  );

  spi_arb_master #(.DATA_W(8), .CLK_DIV(1)) u_min (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(m_req0_valid), .req0_data(m_req0_data), .req0_ready(m_req0_ready),
    .rsp0_valid(m_rsp0_valid), .rsp0_data(m_rsp0_data),
    .req1_valid(m_req1_valid), .req1_data(m_req1_data), .req1_ready(m_req1_ready),
    .rsp1_valid(m_rsp1_valid), .rsp1_data(m_rsp1_data),
    .spi_sclk(m_sclk), .spi_mosi(m_mosi), .spi_miso(m_miso), .spi_ss_n(m_ss_n),
    .busy(m_busy), .grant(m_grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mode-0 slave: presents its MSB when selected, advances on each SCLK fall.
  always @(negedge spi_sclk or posedge spi_ss_n) begin
    if (spi_ss_n)              slv_idx <= 4'd15;
    else if (slv_idx != 4'd0)  slv_idx <= slv_idx - 4'd1;
  end
  assign spi_miso = loop_mode ? spi_mosi : (spi_ss_n ? 1'b0 : slv_word[slv_idx]);
  assign m_miso   = m_mosi;

  typedef struct packed {
    logic          v0, v1, keep, loop, gap_chk;
    logic [DW-1:0] d0, d1, slave;
    logic          exp_grant;
    logic [DW-1:0] exp_rsp, exp_mosi;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic v0, input logic v1, input logic keep, input logic loop,
                              input logic gap_chk, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [DW-1:0] slave, input logic exp_grant,
                              input logic [DW-1:0] exp_rsp, input logic [DW-1:0] exp_mosi);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.keep = keep; v.loop = loop; v.gap_chk = gap_chk;
    v.d0 = d0; v.d1 = d1; v.slave = slave; v.exp_grant = exp_grant;
    v.exp_rsp = exp_rsp; v.exp_mosi = exp_mosi;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL [%s] %s: got 0x%0h expected 0x%0h", tag, name, act, exp);
  endtask

  // Called right after inputs are driven on a falling clock edge.
  task automatic wait_ready(output logic got);
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      #1;
      if (req0_ready || req1_ready) begin
        got = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic got, win1, prev_sclk, prev_mosi;
    logic [DW-1:0] mw;
    int ss_cnt, rises, viol, stray, first_rise, rsp_k, acc;
    @(negedge clk);
    loop_mode  = v.loop;
    slv_word   = v.slave;
    req0_valid = v.v0;
    req1_valid = v.v1;
    req0_data  = v.d0;
    req1_data  = v.d1;
    wait_ready(got);
    chk("accepted", 32'(got), 32'd1);
    if (!got) return;
    win1 = req1_ready;
    acc  = cyc;
    chk("ready_index", 32'(win1), 32'(v.exp_grant));
    chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
    if (v.gap_chk) chk("accept_spacing", acc - prev_acc, SPACING);
    prev_acc = acc;
    ss_cnt = 0; rises = 0; viol = 0; stray = 0; first_rise = 0; rsp_k = 0;
    mw = '0; prev_sclk = 1'b0; prev_mosi = spi_mosi; got = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1 && !v.keep) begin
        if (win1) req1_valid = 1'b0;
        else      req0_valid = 1'b0;
      end
      #1;
      if (k == 1) begin
        chk("ss_fall", 32'(spi_ss_n), 32'd0);
        chk("busy_rise", 32'(busy), 32'd1);
        chk("grant_out", 32'(grant), 32'(v.exp_grant));
      end
      if (!spi_ss_n) ss_cnt++;
      if (spi_sclk && !prev_sclk) begin
        rises++;
        mw = {mw[DW-2:0], spi_mosi};
        if (rises == 1) first_rise = k;
      end
      if (spi_sclk && (spi_mosi !== prev_mosi)) viol++;
      if (req0_ready || req1_ready) stray++;
      if (win1 ? rsp0_valid : rsp1_valid) stray++;
      if (win1 ? rsp1_valid : rsp0_valid) begin
        got = 1'b1;
        rsp_k = k;
        break;
      end
      prev_sclk = spi_sclk;
      prev_mosi = spi_mosi;
    end
    chk("rsp_seen", 32'(got), 32'd1);
    chk("rsp_cycle", rsp_k, SS_LOW + 1);
    chk("rsp_data", 32'(win1 ? rsp1_data : rsp0_data), 32'(v.exp_rsp));
    chk("ss_at_rsp", 32'(spi_ss_n), 32'd1);
    chk("ss_low_cycles", ss_cnt, SS_LOW);
    chk("sclk_rises", rises, DW);
    chk("first_rise", first_rise, 1 + CD);
    chk("mosi_word", 32'(mw), 32'(v.exp_mosi));
    chk("mosi_change_sclk_high", viol, 0);
    chk("stray_handshake", stray, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL [watchdog] simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic got;
    int rises, early, idle_k, seen0, stray, ss_cnt, rsp_k, first_rise;
    logic idle_rdy, prev_sclk;
    logic [DW-1:0] r0;
    logic [7:0] mw8;

    //        v0  v1  keep loop gap  d0        d1        slave     g   rsp       mosi
    vecs[0] = mk(1, 0, 0, 1, 0, 16'hA5C3, 16'h0000, 16'h0000, 0, 16'hA5C3, 16'hA5C3);
    vecs[1] = mk(0, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 16'h0001, 1, 16'h0001, 16'hFFFF);
    vecs[2] = mk(1, 1, 1, 1, 0, 16'h1234, 16'hBEEF, 16'h0000, 0, 16'h1234, 16'h1234);
    vecs[3] = mk(1, 1, 1, 1, 1, 16'h1234, 16'hBEEF, 16'h0000, 1, 16'hBEEF, 16'hBEEF);
    vecs[4] = mk(1, 1, 1, 1, 1, 16'h0F0F, 16'hBEEF, 16'h0000, 0, 16'h0F0F, 16'h0F0F);
    vecs[5] = mk(1, 1, 0, 1, 1, 16'h0F0F, 16'h8001, 16'h0000, 1, 16'h8001, 16'h8001);
    vecs[6] = mk(1, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'hFFFF, 0, 16'hFFFF, 16'h0000);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ss_n", 32'(spi_ss_n), 32'd1);
    chk("rst_sclk", 32'(spi_sclk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    chk("rst_rsp_data", 32'({rsp0_data, rsp1_data}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (8) @(negedge clk);

    tag = "busy_req";
    loop_mode = 1'b1;
    req0_data = 16'h5A5A; req0_valid = 1'b1;
    req1_data = 16'h1357;
    wait_ready(got);
    chk("accept0", 32'({got, req0_ready}), 32'd3);
    early = 0; idle_k = 0; seen0 = 0; idle_rdy = 1'b0; r0 = '0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1)  req0_valid = 1'b0;
      if (k == 50) req1_valid = 1'b1;
      #1;
      if (rsp0_valid) begin seen0++; r0 = rsp0_data; end
      if (busy && req1_ready) early++;
      if (!busy) begin idle_k = k; idle_rdy = req1_ready; break; end
    end
    chk("no_ready_while_busy", early, 0);
    chk("idle_cycle", idle_k, SPACING);
    chk("ready1_first_idle", 32'(idle_rdy), 32'd1);
    chk("rsp0_count", seen0, 1);
    chk("rsp0_data", 32'(r0), 32'h5A5A);
    rsp_k = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) req1_valid = 1'b0;
      #1;
      if (rsp1_valid) begin rsp_k = k; break; end
    end
    chk("rsp1_cycle", rsp_k, SS_LOW + 1);
    chk("rsp1_data", 32'(rsp1_data), 32'h1357);
    repeat (6) @(negedge clk);

    tag = "reset_mid";
    req0_data = 16'hC0DE; req0_valid = 1'b1;
    wait_ready(got);
    chk("accept0", 32'({got, req0_ready}), 32'd3);
    rises = 0; prev_sclk = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) req0_valid = 1'b0;
      #1;
      if (spi_sclk && !prev_sclk) rises++;
      prev_sclk = spi_sclk;
      if (rises == 8) break;
    end
    chk("reached_rise8", rises, 8);
    reset_n = 1'b0;
    #1;
    chk("ss_n_now", 32'(spi_ss_n), 32'd1);
    chk("sclk_now", 32'(spi_sclk), 32'd0);
    chk("busy_now", 32'(busy), 32'd0);
    chk("mosi_now", 32'(spi_mosi), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 16'h6C6C; req1_data = 16'h9393;
    stray = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (rsp0_valid || rsp1_valid || req0_ready || req1_ready) stray++;
    end
    chk("quiet_in_reset", stray, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_vec(mk(1, 1, 0, 1, 0, 16'h6C6C, 16'h9393, 16'h0000, 0, 16'h6C6C, 16'h6C6C));
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (8) @(negedge clk);

    tag = "min_div";
    m_req0_data = 8'h3C; m_req0_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (m_req0_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", 32'(got), 32'd1);
    ss_cnt = 0; rises = 0; rsp_k = 0; first_rise = 0; mw8 = '0; prev_sclk = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) m_req0_valid = 1'b0;
      #1;
      if (!m_ss_n) ss_cnt++;
      if (m_sclk && !prev_sclk) begin
        rises++;
        mw8 = {mw8[6:0], m_mosi};
        if (rises == 1) first_rise = k;
      end
      prev_sclk = m_sclk;
      if (m_rsp0_valid) begin rsp_k = k; break; end
    end
    chk("ss_low_cycles", ss_cnt, 17);
    chk("sclk_rises", rises, 8);
    chk("first_rise", first_rise, 2);
    chk("rsp_cycle", rsp_k, 18);
    chk("mosi_word", 32'(mw8), 32'h3C);
    chk("rsp_data", 32'(m_rsp0_data), 32'h3C);
    chk("rsp1_quiet", 32'(m_rsp1_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
